// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the sequencer states, the grant ids and the default widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 2;
    localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker, zero latency.
// Never backpressures; lock_active restricts the grant to requester 1.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] vld,
    input  logic       last_grant,
    input  logic       lock_active,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt = 2'b00;
        if (lock_active) begin
            gnt = {vld[1], 1'b0};
        end else if (&vld) begin
            // On a tie the requester that did not win last time goes first.
            gnt = (last_grant == REQ_DBG) ? 2'b01 : 2'b10;
        end else begin
            gnt = vld;
        end
        gnt_id = gnt[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the data-memory port; response MEM_LATENCY+2 cycles after handshake.
// One outstanding transaction: rdy only in IDLE. Optional MEM_ARB_LOCK_EN adds a requester-1 lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = MEM_LAT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_vld,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    input  logic              i_req0_wren,
    input  logic [DATA_W/8-1:0] i_req0_bmask,
    input  logic              i_req1_vld,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    input  logic              i_req1_wren,
    input  logic [DATA_W/8-1:0] i_req1_bmask,
`ifdef MEM_ARB_LOCK_EN
    input  logic              i_req1_lock,
`endif
    output logic              o_req0_rdy,
    output logic              o_req1_rdy,
    output logic              o_req0_rvalid,
    output logic              o_req1_rvalid,
    output logic [DATA_W-1:0] o_req0_rdata,
    output logic [DATA_W-1:0] o_req1_rdata,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   last_grant_q, last_grant_d;
    logic                   gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   wren_q, wren_d;
    logic [DATA_W/8-1:0]    bmask_q, bmask_d;
    logic [DATA_W-1:0]      rdata0_q, rdata0_d;
    logic [DATA_W-1:0]      rdata1_q, rdata1_d;
    logic                   lock_active;
    logic [1:0]             gnt;
    logic                   gnt_id;
    logic [DATA_W-1:0]      cap_data;

`ifdef MEM_ARB_LOCK_EN
    logic                   lock_q, lock_d;
    logic                   lock_active_q, lock_active_d;
    assign lock_active = lock_active_q;
`else
    assign lock_active = 1'b0;
`endif

    mem_arb_rr_pick u_pick (
        .vld         ({i_req1_vld, i_req0_vld}),
        .last_grant  (last_grant_q),
        .lock_active (lock_active),
        .gnt         (gnt),
        .gnt_id      (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wren_d       = wren_q;
        bmask_d      = bmask_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cap_data     = wren_q ? '0 : i_mem_rdata;
`ifdef MEM_ARB_LOCK_EN
        lock_d        = lock_q;
        lock_active_d = lock_active_q;
`endif
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    gnt_id_d     = gnt_id;
                    last_grant_d = gnt_id;
                    addr_d       = (gnt_id == REQ_DBG) ? i_req1_addr  : i_req0_addr;
                    wdata_d      = (gnt_id == REQ_DBG) ? i_req1_wdata : i_req0_wdata;
                    wren_d       = (gnt_id == REQ_DBG) ? i_req1_wren  : i_req0_wren;
                    bmask_d      = (gnt_id == REQ_DBG) ? i_req1_bmask : i_req0_bmask;
`ifdef MEM_ARB_LOCK_EN
                    lock_d       = (gnt_id == REQ_DBG) & i_req1_lock;
`endif
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_CNT_W'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_id_q == REQ_DBG) rdata1_d = cap_data;
                    else                     rdata0_d = cap_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP: begin
`ifdef MEM_ARB_LOCK_EN
                if (gnt_id_q == REQ_DBG) lock_active_d = lock_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ_DBG;
            gnt_id_q     <= REQ_CORE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            bmask_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_q        <= 1'b0;
            lock_active_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            bmask_q      <= bmask_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef MEM_ARB_LOCK_EN
            lock_q        <= lock_d;
            lock_active_q <= lock_active_d;
`endif
        end
    end

    assign o_req0_rdy    = (state_q == IDLE) & gnt[0] & ~i_reset;
    assign o_req1_rdy    = (state_q == IDLE) & gnt[1] & ~i_reset;
    assign o_req0_rvalid = (state_q == RESP) & (gnt_id_q == REQ_CORE);
    assign o_req1_rvalid = (state_q == RESP) & (gnt_id_q == REQ_DBG);
    assign o_req0_rdata  = rdata0_q;
    assign o_req1_rdata  = rdata1_q;
    assign o_mem_req     = (state_q == ISSUE);
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_mem_wren    = wren_q;
    assign o_mem_bmask   = bmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=2: load, store, ties, stall, mid-WAIT reset, lock.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        r0_vld, r1_vld;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_wren, r1_wren;
    logic [3:0]  r0_bmask, r1_bmask;
`ifdef MEM_ARB_LOCK_EN
    logic        r1_lock;
`endif
    logic        o_req0_rdy, o_req1_rdy, o_req0_rvalid, o_req1_rvalid;
    logic [31:0] o_req0_rdata, o_req1_rdata;
    logic        o_mem_req, o_mem_wren;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic [31:0] i_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req0_vld    (r0_vld),
        .i_req0_addr   (r0_addr),
        .i_req0_wdata  (r0_wdata),
        .i_req0_wren   (r0_wren),
        .i_req0_bmask  (r0_bmask),
        .i_req1_vld    (r1_vld),
        .i_req1_addr   (r1_addr),
        .i_req1_wdata  (r1_wdata),
        .i_req1_wren   (r1_wren),
        .i_req1_bmask  (r1_bmask),
`ifdef MEM_ARB_LOCK_EN
        .i_req1_lock   (r1_lock),
`endif
        .o_req0_rdy    (o_req0_rdy),
        .o_req1_rdy    (o_req1_rdy),
        .o_req0_rvalid (o_req0_rvalid),
        .o_req1_rvalid (o_req1_rvalid),
        .o_req0_rdata  (o_req0_rdata),
        .o_req1_rdata  (o_req1_rdata),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_wren    (o_mem_wren),
        .o_mem_bmask   (o_mem_bmask),
        .i_mem_rdata   (i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle in IDLE with the winner's request already presented.
    task automatic xact(input bit w, input logic [31:0] eaddr, input logic [31:0] ewdata,
                        input bit ewren, input logic [3:0] ebm, input logic [31:0] mdata);
        logic [31:0] erd;
        erd = ewren ? 32'h0 : mdata;
        chk("rdy_winner", w ? o_req1_rdy : o_req0_rdy, 32'd1);
        chk("rdy_loser",  w ? o_req0_rdy : o_req1_rdy, 32'd0);
        @(posedge i_clk); #1;
        if (w) r1_vld = 1'b0; else r0_vld = 1'b0;
        #1;
        chk("mem_req_issue", o_mem_req, 32'd1);
        chk("mem_addr", o_mem_addr, eaddr);
        chk("mem_wdata", o_mem_wdata, ewdata);
        chk("mem_wren", o_mem_wren, ewren);
        chk("mem_bmask", o_mem_bmask, ebm);
        chk("rdy_busy", {o_req1_rdy, o_req0_rdy}, 32'd0);
        @(posedge i_clk); #2;
        chk("mem_req_once", o_mem_req, 32'd0);
        chk("mem_addr_hold", o_mem_addr, eaddr);
        @(posedge i_clk); #1;
        i_mem_rdata = mdata;
        #1;
        chk("rvalid_early", {o_req1_rvalid, o_req0_rvalid}, 32'd0);
        @(posedge i_clk); #1;
        i_mem_rdata = ~mdata;
        #1;
        chk("rvalid_winner", w ? o_req1_rvalid : o_req0_rvalid, 32'd1);
        chk("rvalid_loser",  w ? o_req0_rvalid : o_req1_rvalid, 32'd0);
        chk("rdata", w ? o_req1_rdata : o_req0_rdata, erd);
        chk("rdy_resp", {o_req1_rdy, o_req0_rdy}, 32'd0);
        @(posedge i_clk); #2;
        chk("rvalid_pulse", w ? o_req1_rvalid : o_req0_rvalid, 32'd0);
        chk("rdata_hold", w ? o_req1_rdata : o_req0_rdata, erd);
    endtask

    initial begin
        i_reset = 1'b1;
        r0_vld = 1'b0; r1_vld = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        r0_wren = 1'b0; r1_wren = 1'b0; r0_bmask = '0; r1_bmask = '0;
`ifdef MEM_ARB_LOCK_EN
        r1_lock = 1'b0;
`endif
        i_mem_rdata = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_rdy", {o_req1_rdy, o_req0_rdy}, 32'd0);
        chk("rst_rvalid", {o_req1_rvalid, o_req0_rvalid}, 32'd0);
        chk("rst_mem_req", o_mem_req, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_rdata0", o_req0_rdata, 32'd0);

        // Single load from requester 0.
        i_reset = 1'b0;
        r0_vld = 1'b1; r0_addr = 32'h100; r0_wren = 1'b0; r0_bmask = 4'hF; r0_wdata = 32'h0;
        #1;
        xact(1'b0, 32'h100, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF);
        chk("load_req1_rdata", o_req1_rdata, 32'd0);

        // Store from requester 1 returns zero data.
        r1_vld = 1'b1; r1_addr = 32'h40; r1_wdata = 32'h12345678; r1_wren = 1'b1; r1_bmask = 4'b0011;
        #1;
        xact(1'b1, 32'h40, 32'h12345678, 1'b1, 4'b0011, 32'hFFFFFFFF);

        // Ties alternate; the held loser is taken in the IDLE right after RESP.
        r0_vld = 1'b1; r0_addr = 32'h200;
        r1_vld = 1'b1; r1_addr = 32'h300; r1_wren = 1'b0; r1_wdata = 32'h0; r1_bmask = 4'hF;
        #1;
        xact(1'b0, 32'h200, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D);
        r0_vld = 1'b1; r0_addr = 32'h204;
        #1;
        xact(1'b1, 32'h300, 32'h0, 1'b0, 4'hF, 32'h11112222);
        r1_vld = 1'b1; r1_addr = 32'h304;
        #1;
        xact(1'b0, 32'h204, 32'h0, 1'b0, 4'hF, 32'h33334444);

        // Reset in WAIT drops the transaction; last_grant returns to requester 1.
        r0_vld = 1'b0; r1_vld = 1'b0;
        @(posedge i_clk); #1;
        r0_vld = 1'b1; r0_addr = 32'h208; r0_wren = 1'b1; r0_wdata = 32'hA5A5A5A5; r0_bmask = 4'hC;
        @(posedge i_clk); #1;
        r0_vld = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        #1;
        chk("mrst_mem_req", o_mem_req, 32'd0);
        chk("mrst_mem_addr", o_mem_addr, 32'd0);
        chk("mrst_mem_wdata", o_mem_wdata, 32'd0);
        chk("mrst_mem_wren", o_mem_wren, 32'd0);
        chk("mrst_mem_bmask", o_mem_bmask, 32'd0);
        chk("mrst_rvalid", {o_req1_rvalid, o_req0_rvalid}, 32'd0);
        chk("mrst_rdata0", o_req0_rdata, 32'd0);
        chk("mrst_rdata1", o_req1_rdata, 32'd0);
        repeat (3) begin
            @(posedge i_clk); #2;
            chk("mrst_no_rvalid", {o_req1_rvalid, o_req0_rvalid}, 32'd0);
        end
        r0_vld = 1'b1; r0_addr = 32'h20C; r0_wren = 1'b0; r0_wdata = 32'h0; r0_bmask = 4'hF;
        r1_vld = 1'b1; r1_addr = 32'h308;
        #1;
        xact(1'b0, 32'h20C, 32'h0, 1'b0, 4'hF, 32'h55667788);
        #1;
        xact(1'b1, 32'h308, 32'h0, 1'b0, 4'hF, 32'h99AABBCC);

`ifdef MEM_ARB_LOCK_EN
        // Locked requester-1 sequence blocks requester 0 until the unlocking access.
        r1_vld = 1'b1; r1_addr = 32'h500; r1_lock = 1'b1;
        #1;
        xact(1'b1, 32'h500, 32'h0, 1'b0, 4'hF, 32'h01020304);
        r1_lock = 1'b0;
        r0_vld = 1'b1; r0_addr = 32'h210;
        #1;
        chk("lock_rdy0_alone", o_req0_rdy, 32'd0);
        r1_vld = 1'b1; r1_addr = 32'h504; r1_wren = 1'b1; r1_wdata = 32'h0A0B0C0D;
        #1;
        xact(1'b1, 32'h504, 32'h0A0B0C0D, 1'b1, 4'hF, 32'h77777777);
        #1;
        xact(1'b0, 32'h210, 32'h0, 1'b0, 4'hF, 32'h13579BDF);
`endif

        repeat (2) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single data-memory port behind the LSU.
- Requester 0 is the core LSU path; requester 1 is the debug/program-loader port.
- Grants one request at a time, round-robin on ties, and issues it to memory with a fixed read latency.
- Returns the response to the winner with a valid pulse.
- Sits between the LSU and the data-memory macro; the core stalls on o_req0_rdy/o_req0_rvalid.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from o_mem_req to valid i_mem_rdata (legal range 1..15)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req0_vld / i_req1_vld  in  1  request valid
- i_req0_addr / i_req1_addr  in  ADDR_W  byte address
- i_req0_wdata / i_req1_wdata  in  DATA_W  store data
- i_req0_wren / i_req1_wren  in  1  1 = store, 0 = load
- i_req0_bmask / i_req1_bmask  in  DATA_W/8  byte enables
- o_req0_rdy / o_req1_rdy  out  1  request accepted this cycle when vld&rdy
- o_req0_rvalid / o_req1_rvalid  out  1  one-cycle response pulse
- o_req0_rdata / o_req1_rdata  out  DATA_W  load data; 0 for stores
- o_mem_req  out  1  one-cycle memory strobe
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_wren  out  1  memory write enable
- o_mem_bmask  out  DATA_W/8  memory byte enables
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after o_mem_req

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Single outstanding transaction; no pipelining.
- IDLE, choosing a winner:
  - Only one vld high: that requester wins.
  - Both high: the requester not in last_grant wins.
  - The winner's o_reqN_rdy is high combinationally in IDLE; the loser's is low. In all other states both rdy are 0.
- IDLE, on handshake:
  - Latch addr, wdata, wren, bmask and grant id.
  - Update last_grant to the winner.
  - Go to ISSUE.
- ISSUE:
  - o_mem_req=1 for exactly one cycle with the latched fields.
  - Load the latency counter with MEM_LATENCY-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, capture i_mem_rdata (or 0 if the transaction is a store) into the response register and go to RESP.
- RESP:
  - o_reqG_rvalid=1 for one cycle with o_reqG_rdata = the captured value.
  - The other requester's rvalid stays 0. Go to IDLE.
- Timing: handshake at cycle T gives o_mem_req at T+1, data capture at T+1+MEM_LATENCY, and rvalid at T+2+MEM_LATENCY.
  - Back-to-back throughput: one transaction per MEM_LATENCY+3 cycles.
- o_mem_* outputs hold their latched values outside ISSUE. Memory must qualify on o_mem_req only.
- o_reqN_rdata holds its last value between pulses. It is valid only with rvalid.
- Reset (synchronous, any state, including mid-WAIT):
  - State=IDLE; counter=0; last_grant=1, so requester 0 wins the first tie.
  - All rdy/rvalid/o_mem_req=0; o_mem_addr/wdata/bmask/wren=0; response registers=0.
  - Any outstanding transaction is dropped with no rvalid. A store already strobed is not undone.
- Requester obligations: fields must stay stable while vld is high and rdy is low. Dropping vld before rdy is legal, and nothing is latched.
- Arbitration is sampled only in IDLE. A request arriving during ISSUE/WAIT/RESP waits.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- Defined:
  - Adds input i_req1_lock (1 bit), latched at handshake alongside the other fields.
  - A requester-1 transaction accepted with lock=1 sets lock_active at its RESP.
  - While lock_active, IDLE grants only requester 1; o_req0_rdy=0.
  - lock_active clears at RESP of a requester-1 transaction accepted with lock=0.
  - Reset clears lock_active. Used for atomic debug read-modify-write.
- Undefined: the port is absent; pure round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Grant ids: REQ_CORE=0, REQ_DBG=1.
  - Default widths, and the counter width constant LAT_CNT_W=4.
- One sub-module, mem_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: vld[1:0], last_grant, lock_active.
  - Outputs: gnt[1:0] one-hot, gnt_id.

Test Plan (MEM_LATENCY=2):
- Single load: req0 addr=0x100 at T, mem returns 0xDEADBEEF at T+3 → o_mem_req at T+1 with addr 0x100, wren=0; o_req0_rvalid at T+4 with rdata=0xDEADBEEF; req1 outputs stay 0.
- Tie after reset: req0 and req1 both valid → req0 granted first, req1 granted in the next IDLE. Repeating the tie alternates 1,0,1…
- Store: req1 addr=0x40, wdata=0x12345678, bmask=4'b0011 → o_mem_wren=1 and bmask=0011 for one cycle; o_req1_rvalid pulse with rdata=0.
- Mid-transaction reset: assert i_reset in WAIT → next cycle IDLE with all outputs 0, no rvalid. A fresh req0 then completes with normal T+4 timing.
- Stall: req1 held valid during an ongoing req0 transaction → o_req1_rdy=0 until IDLE; accepted in the cycle after req0's RESP.
- MEM_ARB_LOCK_EN: req1 with lock=1 completes; req0 and req1(lock=0) then both valid → req1 granted, req0 blocked. After req1(lock=0) RESP, req0 is granted.
